// File: rtl/gcd_lcm_unit_if.sv
// Command/status bundle between the RV32 datapath and the GCD/LCM coprocessor.
// The datapath side is the master and the coprocessor side is the slave.
interface gcd_lcm_unit_if #(
  parameter int OPW = 8
);
  logic             cmd_valid;
  logic [31:0]      cmd_word;
  logic             busy;
  logic             done;
  logic [2*OPW-1:0] result;
  logic [31:0]      status_word;

  modport master (
    output cmd_valid, cmd_word,
    input  busy, done, result, status_word
  );

  modport slave (
    input  cmd_valid, cmd_word,
    output busy, done, result, status_word
  );
endinterface

// File: rtl/gcd_lcm_unit.sv
// Multi-cycle GCD (repeated subtraction) / LCM (add-chase) coprocessor with a packed command word.
// Define GCDLCM_PENDING_EN to add a one-entry slot that queues one command arriving while busy.
module gcd_lcm_unit #(
  parameter int OPW = 8
) (
  input logic           clk,
  input logic           reset,
  gcd_lcm_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_GCD_RUN,
    S_LCM_RUN,
    S_DONE
  } state_e;

  localparam int RW = 2 * OPW;

  state_e          state_q;
  logic [OPW-1:0]  a_q, b_q;
  logic [RW-1:0]   m1_q, m2_q, result_q;
  logic            op_q, busy_q, done_q, rvalid_q;

  logic [OPW-1:0]  cmd_x, cmd_y;
  logic            cmd_req, cmd_op, cmd_hit, running, accept;
  logic            launch, ld_op;
  logic [OPW-1:0]  ld_x, ld_y;
  logic [31:0]     status_w;
  logic            unused_cmd_bits;

  assign cmd_x   = bus.cmd_word[OPW-1:0];
  assign cmd_y   = bus.cmd_word[2*OPW-1:OPW];
  assign cmd_req = bus.cmd_word[2*OPW];
  assign cmd_op  = bus.cmd_word[2*OPW+1];
  assign unused_cmd_bits = ^bus.cmd_word[31:2*OPW+2];

  assign cmd_hit = bus.cmd_valid && cmd_req;
  assign running = (state_q == S_CHECK) || (state_q == S_GCD_RUN) || (state_q == S_LCM_RUN);
  assign accept  = cmd_hit && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef GCDLCM_PENDING_EN
  logic            pend_full_q, pend_op_q;
  logic [OPW-1:0]  pend_x_q, pend_y_q;

  // A full slot always wins in DONE; a same-cycle direct command takes its place.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    launch = accept;
    ld_x   = cmd_x;
    ld_y   = cmd_y;
    ld_op  = cmd_op;
    if ((state_q == S_DONE) && pend_full_q) begin
      launch = 1'b1;
      ld_x   = pend_x_q;
      ld_y   = pend_y_q;
      ld_op  = pend_op_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_full_q <= 1'b0;
      pend_op_q   <= 1'b0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
    end else if ((state_q == S_DONE) && pend_full_q) begin
      pend_full_q <= accept;
      if (accept) begin
        pend_op_q <= cmd_op;
        pend_x_q  <= cmd_x;
        pend_y_q  <= cmd_y;
      end
    end else if (running && cmd_hit && !pend_full_q) begin
      pend_full_q <= 1'b1;
      pend_op_q   <= cmd_op;
      pend_x_q    <= cmd_x;
      pend_y_q    <= cmd_y;
    end
  end
`else
  assign launch = accept;
  assign ld_x   = cmd_x;
  assign ld_y   = cmd_y;
  assign ld_op  = cmd_op;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m1_q     <= '0;
      m2_q     <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (launch) begin
            a_q     <= ld_x;
            b_q     <= ld_y;
            op_q    <= ld_op;
            state_q <= S_CHECK;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_CHECK: begin
          // Zero operands park the answer in a/b so the usual equal-compare edge publishes it.
          if ((a_q == '0) || (b_q == '0)) begin
            a_q     <= op_q ? '0 : (a_q | b_q);
            b_q     <= op_q ? '0 : (a_q | b_q);
            state_q <= S_GCD_RUN;
          end else if (op_q) begin
            m1_q    <= {{OPW{1'b0}}, a_q};
            m2_q    <= {{OPW{1'b0}}, b_q};
            state_q <= S_LCM_RUN;
          end else begin
            state_q <= S_GCD_RUN;
          end
        end
        S_GCD_RUN: begin
          if (a_q == b_q) begin
            result_q <= {{OPW{1'b0}}, a_q};
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            rvalid_q <= 1'b1;
          end else if (a_q > b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end
        S_LCM_RUN: begin
          if (m1_q == m2_q) begin
            result_q <= m1_q;
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            rvalid_q <= 1'b1;
          end else if (m1_q < m2_q) begin
            m1_q <= m1_q + {{OPW{1'b0}}, a_q};
          end else begin
            m2_q <= m2_q + {{OPW{1'b0}}, b_q};
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    status_w         = '0;
    status_w[31]     = busy_q;
    status_w[30]     = rvalid_q;
    status_w[RW-1:0] = result_q;
`ifdef GCDLCM_PENDING_EN
    status_w[29]     = pend_full_q;
`endif
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.status_word = status_w;

endmodule
